// File: rtl/tlp_xcvr_pkg.sv
// Shared F2C chunk-ring geometry: chunk size and the index/offset types.
// Ports: none (package only).
// Geometry: 8 ring slots of 128-byte chunks, which gives 16 QWs per chunk.
package tlp_xcvr_pkg;

    localparam int F2C_CHUNKSIZE = 128;
    localparam int F2C_IDX_W     = 3;
    localparam int F2C_OFF_W     = $clog2(F2C_CHUNKSIZE / 8);

    typedef logic [F2C_IDX_W-1:0] F2CChunkIndex;
    typedef logic [F2C_OFF_W-1:0] F2CChunkOffset;

endpackage

// File: rtl/f2c_producer.sv
// Purpose: fills the F2C chunk ring with a deterministic QW stream, one whole chunk at a time,
//          and keeps a running 64-bit checksum of every QW it writes.
// Latency: the first write comes 1 cycle after start; wrIndex_out moves 1 cycle after the last write.
//          Chunk period is N + 2 + GAP_INIT cycles.
// Backpressure: a new chunk starts only when the ring is not full (wr+1 != rd); a started chunk always completes.
// Ports: sysClk_in/sysRstN_in (sync, active-low), en_in, rdIndex_in -> wrIndex_out,
//        ramWr{En,Addr,Data}_out, csData_out, csValid_out.
// Config: defining F2C_PRODUCER_LFSR_EN turns the generator into a 64-bit LFSR (taps 64,63,61,60).
//         By default it is an incrementing counter.
module f2c_producer
    import tlp_xcvr_pkg::*;
#(
    parameter int unsigned GAP_INIT  = 128,
    parameter logic [63:0] DATA_INIT = 64'h0
) (
    input  logic                                          sysClk_in,
    input  logic                                          sysRstN_in,
    input  logic                                          en_in,
    input  F2CChunkIndex                                  rdIndex_in,
    output F2CChunkIndex                                  wrIndex_out,
    output logic                                          ramWrEn_out,
    output logic [$bits(F2CChunkIndex)+$bits(F2CChunkOffset)-1:0] ramWrAddr_out,
    output logic [63:0]                                   ramWrData_out,
    output logic [63:0]                                   csData_out,
    output logic                                          csValid_out
);

    localparam int IDX_W = $bits(F2CChunkIndex);
    localparam int OFF_W = $bits(F2CChunkOffset);

`ifdef F2C_PRODUCER_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [63:0] GEN_SEED = (DATA_INIT == 64'h0) ? 64'h1 : DATA_INIT;

    function automatic logic [63:0] gen_next(input logic [63:0] g);
        return {g[62:0], g[63] ^ g[62] ^ g[60] ^ g[59]};
    endfunction
`else
    localparam logic [63:0] GEN_SEED = DATA_INIT;

    function automatic logic [63:0] gen_next(input logic [63:0] g);
        return g + 64'd1;
    endfunction
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_COMMIT,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    F2CChunkIndex  wr_idx_q, wr_idx_d;
    F2CChunkOffset offset_q, offset_d;
    logic [63:0]   cksum_q, cksum_d;
    logic [63:0]   gen_q, gen_d;
    logic [31:0]   count_q, count_d;
    logic          ring_full;

    // One slot is always left empty so that a full ring can be told apart from an empty one.
    assign ring_full = (F2CChunkIndex'(wr_idx_q + IDX_W'(1)) == rdIndex_in);

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        offset_d = offset_q;
        cksum_d  = cksum_q;
        gen_d    = gen_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (en_in && !ring_full) begin
                    state_d  = S_WRITE;
                    offset_d = '0;
                end
            end
            S_WRITE: begin
                // en_in is ignored here so that a chunk is never truncated.
                cksum_d  = cksum_q + gen_q;
                gen_d    = gen_next(gen_q);
                offset_d = offset_q + OFF_W'(1);
                if (offset_q == '1) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // The index moves only after the last QW has been written, so the host never sees a partial chunk.
                wr_idx_d = wr_idx_q + IDX_W'(1);
                if (GAP_INIT == 0) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = GAP_INIT - 32'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The count runs from GAP_INIT-1 down to 0, which is exactly GAP_INIT cycles.
                if (count_q == 32'd0) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysClk_in) begin
        if (!sysRstN_in) begin
            state_q  <= S_IDLE;
            wr_idx_q <= '0;
            offset_q <= '0;
            cksum_q  <= '0;
            gen_q    <= GEN_SEED;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            offset_q <= offset_d;
            cksum_q  <= cksum_d;
            gen_q    <= gen_d;
            count_q  <= count_d;
        end
    end

    assign wrIndex_out   = wr_idx_q;
    assign ramWrEn_out   = (state_q == S_WRITE);
    assign ramWrAddr_out = {wr_idx_q, offset_q};
    assign ramWrData_out = gen_q;
    assign csData_out    = cksum_q;
    assign csValid_out   = (wr_idx_q == rdIndex_in);

endmodule

// File: tb/tb_f2c_producer.sv
// Scoreboard bench for f2c_producer.
// Expected QWs come from a chunk-level stream model and are queued ahead of time;
// a negedge monitor compares every write and the checksum that follows it.
// Directed phases cover reset, latency, gap, ring full and wrap, en drop, and mid-chunk reset;
// a randomized host phase follows.
module tb_f2c_producer;
    import tlp_xcvr_pkg::*;

    localparam int IDX_W = $bits(F2CChunkIndex);
    localparam int OFF_W = $bits(F2CChunkOffset);
    localparam int N     = F2C_CHUNKSIZE / 8;
    localparam int NCH   = 1 << IDX_W;
    localparam int GAP   = 4;
`ifdef F2C_PRODUCER_LFSR_EN
    localparam logic [63:0] SEED = 64'h1;
`else
    localparam logic [63:0] SEED = 64'h0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    F2CChunkIndex           rd = '0;
    F2CChunkIndex           wr_idx;
    logic                   ram_wr_en;
    logic [IDX_W+OFF_W-1:0] ram_wr_addr;
    logic [63:0]            ram_wr_data;
    logic [63:0]            cs_data;
    logic                   cs_valid;

    always #5 clk = ~clk;

    f2c_producer #(.GAP_INIT(GAP), .DATA_INIT(64'h0)) dut (
        .sysClk_in    (clk),
        .sysRstN_in   (rst_n),
        .en_in        (en),
        .rdIndex_in   (rd),
        .wrIndex_out  (wr_idx),
        .ramWrEn_out  (ram_wr_en),
        .ramWrAddr_out(ram_wr_addr),
        .ramWrData_out(ram_wr_data),
        .csData_out   (cs_data),
        .csValid_out  (cs_valid)
    );

    typedef struct {
        logic [IDX_W+OFF_W-1:0] addr;
        logic [63:0]            data;
        logic [63:0]            cs;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic [63:0] m_data, m_sum;
    int          m_chunk;
    bit          pend = 0;
    logic [63:0] pend_cs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Stream model: successive QWs of the generator sequence, laid out chunk after chunk around the ring.
    function automatic logic [63:0] ref_next(input logic [63:0] x);
`ifdef F2C_PRODUCER_LFSR_EN
        logic fb;
        fb = x[63] ^ x[62] ^ x[60] ^ x[59];
        return (x << 1) | {63'b0, fb};
`else
        return x + 64'd1;
`endif
    endfunction

    task automatic model_reset();
        m_data  = SEED;
        m_sum   = 64'h0;
        m_chunk = 0;
        exp_q.delete();
        pend    = 0;
    endtask

    task automatic push_chunk(output logic [63:0] sum_after);
        exp_t e;
        for (int off = 0; off < N; off++) begin
            m_sum  = m_sum + m_data;
            e.addr = {IDX_W'(m_chunk), OFF_W'(off)};
            e.data = m_data;
            e.cs   = m_sum;
            exp_q.push_back(e);
            m_data = ref_next(m_data);
        end
        m_chunk   = (m_chunk + 1) % NCH;
        sum_after = m_sum;
    endtask

    // Monitor: each write must match the head of the queue; the checksum must follow one cycle later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend) begin
                check("cs_after_write", cs_data, pend_cs);
                pend = 0;
            end
            if (ram_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none required", ram_wr_addr, ram_wr_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(ram_wr_addr), 64'(e.addr));
                    check("wr_data", ram_wr_data, e.data);
                    pend    = 1;
                    pend_cs = e.cs;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idx(input F2CChunkIndex v, input int budget, output int n);
        n = 0;
        while (wr_idx !== v && n < budget) begin
            tick();
            n++;
        end
        if (wr_idx !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_idx_timeout: wrIndex %0d, required %0d", wr_idx, v);
        end
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (wr_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_wr_timeout: writes %0d, required %0d", wr_cnt, target);
        end
    endtask

    initial begin
        logic [63:0] sum0, sum1, dummy;
        int n, n2, base, base2;

        // Reset state
        model_reset();
        repeat (3) tick();
        check("rst_wr_en", 64'(ram_wr_en), 64'h0);
        check("rst_cs_data", cs_data, 64'h0);
        check("rst_wr_idx", 64'(wr_idx), 64'h0);
        check("rst_cs_valid", 64'(cs_valid), 64'h1);

        // First chunk: latency to commit, checksum, and host not yet caught up
        push_chunk(sum0);
        push_chunk(sum1);
        en    = 1'b1;
        rst_n = 1'b1;
        wait_idx(F2CChunkIndex'(1), 100, n);
        check("commit_latency", 64'(n), 64'(N + 2));
        check("cs_chunk0", cs_data, sum0);
        check("cs_valid_behind", 64'(cs_valid), 64'h0);

        // Second chunk starts GAP idle cycles after the commit
        n2 = 0;
        while (!ram_wr_en && n2 < 50) begin
            tick();
            n2++;
        end
        check("gap_to_next_write", 64'(n2), 64'(GAP + 1));
        rd = F2CChunkIndex'(1);
        #1;
        check("cs_valid_caught_up", 64'(cs_valid), 64'h1);
        wait_idx(F2CChunkIndex'(2), 100, n);
        check("cs_chunk1", cs_data, sum1);

        // Host stuck at 0: fill NCH-1 chunks, stall, then release and wrap
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rd = '0;
        for (int c = 0; c < NCH; c++) push_chunk(dummy);
        rst_n = 1'b1;
        wait_idx(F2CChunkIndex'(NCH - 1), 2000, n);
        base = wr_cnt;
        repeat (30) tick();
        check("full_stall_writes", 64'(wr_cnt), 64'(base));
        check("full_wr_en", 64'(ram_wr_en), 64'h0);
        rd = F2CChunkIndex'(1);
        tick();
        check("resume_wr_en", 64'(ram_wr_en), 64'h1);
        check("resume_addr", 64'(ram_wr_addr), 64'((NCH - 1) << OFF_W));
        wait_idx(F2CChunkIndex'(0), 100, n);
        check("wrap_queue_drained", 64'(exp_q.size()), 64'h0);

        // Drop en_in at the 5th write: the chunk still completes, then the producer idles
        push_chunk(dummy);
        base = wr_cnt;
        rd   = '0;
        wait_wr(base + 5, 100);
        en = 1'b0;
        wait_idx(F2CChunkIndex'(1), 100, n);
        base2 = wr_cnt;
        check("en_drop_full_chunk", 64'(base2 - base), 64'(N));
        repeat (40) tick();
        check("en_low_no_start", 64'(wr_cnt), 64'(base2));

        // Reset at the 8th write abandons the chunk
        rd = F2CChunkIndex'(1);
        push_chunk(dummy);
        base = wr_cnt;
        en   = 1'b1;
        wait_wr(base + 8, 100);
        rst_n = 1'b0;
        model_reset();
        tick();
        check("midrst_wr_en", 64'(ram_wr_en), 64'h0);
        check("midrst_wr_idx", 64'(wr_idx), 64'h0);
        check("midrst_cs", cs_data, 64'h0);
        rd = '0;
        push_chunk(dummy);
        tick();
        rst_n = 1'b1;
        wait_idx(F2CChunkIndex'(1), 200, n);
        check("restart_queue_drained", 64'(exp_q.size()), 64'h0);

        // Randomized host draining and en toggling
        for (int c = 0; c < 20; c++) push_chunk(dummy);
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            tick();
            n++;
            en = ($urandom_range(3) != 0);
            if (rd != wr_idx && $urandom_range(2) == 0) rd = rd + F2CChunkIndex'(1);
        end
        en = 1'b0;
        wait_idx(F2CChunkIndex'(m_chunk), 100, n);
        check("random_final_cs", cs_data, m_sum);
        check("random_queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
